// File: rtl/weight_pkg.sv
// Shared types and constants for the weight-buffer load controller.
package weight_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} wctrl_state_t;

  localparam int WORD_W         = 32;
  localparam int ELEMS_PER_WORD = 2;
  localparam int CREDIT_W       = $clog2(ELEMS_PER_WORD + 1);

endpackage

// File: rtl/wb_occupancy_cnt.sv
// Buffer occupancy in elements: up by the credit of an accepted word, down by
// one per pop, with the full/empty compares the handshake logic needs.
module wb_occupancy_cnt
  import weight_pkg::*;
#(
  parameter int BUF_ELEMS = 14,
  parameter int CNT_W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [CREDIT_W-1:0] wr_credit,
  input  logic                rd_en,
  output logic [CNT_W-1:0]    occ,
  output logic                full,
  output logic                empty
);

  logic [CNT_W-1:0] occ_q, occ_d;

  always_comb begin
    occ_d = occ_q;
    if (wr_en) occ_d = occ_d + CNT_W'(wr_credit);
    if (rd_en) occ_d = occ_d - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) occ_q <= '0;
    else     occ_q <= occ_d;
  end

  // "full" means another whole word might not fit, not that the buffer is at capacity.
  assign full  = occ_q > CNT_W'(BUF_ELEMS - ELEMS_PER_WORD);
  assign empty = occ_q == '0;
  assign occ   = occ_q;

  a_no_overflow:  assert property (@(posedge clk) disable iff (rst) occ_q <= CNT_W'(BUF_ELEMS));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) rd_en |-> !empty);

endmodule

// File: rtl/weight_buf_ctrl.sv
// Sequences one weight-load job: AXI words into the weight buffer, elements
// out to the PE array under back-pressure, and a done pulse at the end.
module weight_buf_ctrl
  import weight_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int BUF_ELEMS  = 14,
  parameter int CNT_W      = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [CNT_W-1:0]                     num_weights,
  input  logic                                 s_valid,
  input  logic [ELEMS_PER_WORD*DATA_WIDTH-1:0] s_data,
  output logic                                 s_ready,
  output logic                                 buf_fifo_en,
  output logic [ELEMS_PER_WORD*DATA_WIDTH-1:0] buf_data_in,
  output logic                                 buf_out_en,
  output logic                                 buf_rst_n,
  input  logic                                 pe_ready,
  output logic                                 weight_valid,
  output logic                                 busy,
  output logic                                 done
);

  wctrl_state_t     state_q, state_d;
  logic [CNT_W-1:0] total_q, total_d;
  logic [CNT_W-1:0] words_left_q, words_left_d;
  logic [CNT_W-1:0] sent_q, sent_d;
  logic             wv_q, wv_d;

  logic [CNT_W-1:0]    occ;
  logic                full, empty;
  logic                accept, pop, odd_tail;
  logic [CREDIT_W-1:0] credit;
  logic [CNT_W-1:0]    words_init;

  // Rounded-up halving done one bit wider so num_weights = all-ones cannot wrap.
  assign words_init = CNT_W'(({1'b0, num_weights} + (CNT_W+1)'(1)) >> 1);

  assign s_ready  = (state_q == LOAD) && (words_left_q != '0) && !full;
  assign accept   = s_valid && s_ready;
  assign odd_tail = (words_left_q == CNT_W'(1)) && total_q[0];
  assign credit   = odd_tail ? CREDIT_W'(1) : CREDIT_W'(ELEMS_PER_WORD);
  assign pop      = ((state_q == LOAD) || (state_q == DRAIN)) && !empty &&
                    pe_ready && (sent_q < total_q);

  always_comb begin
    state_d      = state_q;
    total_d      = total_q;
    words_left_d = words_left_q;
    sent_d       = sent_q;
    wv_d         = pop;
    if (pop) sent_d = sent_q + CNT_W'(1);
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (num_weights != '0) begin
            state_d      = LOAD;
            total_d      = num_weights;
            words_left_d = words_init;
            sent_d       = '0;
          end else begin
            state_d = DONE;
          end
        end
      end
      LOAD: begin
        if (accept) begin
          words_left_d = words_left_q - CNT_W'(1);
          if (words_left_q == CNT_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: if (sent_q == total_q) state_d = DONE;
      DONE:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      total_q      <= '0;
      words_left_q <= '0;
      sent_q       <= '0;
      wv_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      total_q      <= total_d;
      words_left_q <= words_left_d;
      sent_q       <= sent_d;
      wv_q         <= wv_d;
    end
  end

  wb_occupancy_cnt #(
    .BUF_ELEMS (BUF_ELEMS),
    .CNT_W     (CNT_W)
  ) u_occ (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (accept),
    .wr_credit (credit),
    .rd_en     (pop),
    .occ       (occ),
    .full      (full),
    .empty     (empty)
  );

  assign buf_fifo_en  = accept;
  assign buf_data_in  = s_data;
  assign buf_out_en   = pop;
  assign buf_rst_n    = ~rst;
  assign weight_valid = wv_q;
  assign busy         = (state_q == LOAD) || (state_q == DRAIN);
  assign done         = (state_q == DONE);

  a_occ_bound: assert property (@(posedge clk) disable iff (rst) occ <= CNT_W'(BUF_ELEMS));

endmodule

// File: doc/weight_buf_ctrl.md
Name: weight_buf_ctrl

Overview:
Sequences one weight-load job for the 16-bit weight buffer.
- Accepts 32-bit words from the AXI side using a valid/ready handshake.
- Drives the buffer's write enable and data, and its read enable.
- Tracks buffer occupancy in elements, so the buffer never overflows and is never read empty.
- Presents weights to the PE array under PE back-pressure and pulses done once all configured weights have been delivered.

Parameters:
DATA_WIDTH, 16, width of one weight element
BUF_ELEMS, 14, buffer capacity in elements (224 bits / 16)
CNT_W, 16, width of the job weight-count and internal counters

Ports:
clk  in  1  clock; one clock domain
rst  in  1  reset; synchronous, active-high
start  in  1  one-cycle job start pulse; sampled only in IDLE
num_weights  in  CNT_W  elements in the job; sampled with start
s_valid  in  1  AXI word valid
s_data  in  32  AXI word; low half is the first element, high half the second
s_ready  out  1  word accepted when s_valid && s_ready
buf_fifo_en  out  1  buffer write enable
buf_data_in  out  32  buffer write data (s_data passthrough)
buf_out_en  out  1  buffer read enable (one element per cycle)
pe_ready  in  1  PE array can take a weight this cycle
weight_valid  out  1  buffer data_out is valid for the PE array this cycle
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse, job complete

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, occupancy=0, words_left=0, sent=0.
  - Outputs s_ready, buf_fifo_en, buf_out_en, weight_valid, busy, done all 0.
  - The buffer's active-low reset must be driven from ~rst, so both blocks are emptied together.
- Reset mid-job: the job is abandoned, no done pulse, and the block returns to IDLE the next cycle.
- FSM states: IDLE, LOAD, DRAIN, DONE.
  - IDLE -> LOAD on start with num_weights != 0.
    - Latch total = num_weights.
    - words_left = ceil(num_weights/2).
    - sent = 0.
  - IDLE -> DONE on start with num_weights == 0.
  - LOAD -> DRAIN when the last word is accepted (words_left goes 1 -> 0).
  - DRAIN -> DONE when sent reaches total.
  - DONE -> IDLE after one cycle; done=1 only in DONE.
  - start outside IDLE is ignored.
- Write side:
  - s_ready = (state==LOAD) && words_left != 0 && occupancy <= BUF_ELEMS-2.
    - This is combinational from registered state; it does not depend on s_valid.
  - buf_fifo_en = s_valid && s_ready.
  - buf_data_in = s_data.
  - On accept, words_left decrements.
  - Element credit for an accepted word is 2, except 1 for the last word of an odd-count job; its high half is written to the buffer but never read.
- Read side:
  - buf_out_en = (state==LOAD || state==DRAIN) && occupancy != 0 && pe_ready && sent < total.
  - On buf_out_en, sent increments and occupancy decrements by 1.
  - weight_valid is buf_out_en registered; the element is presented one cycle after the pop, matching the buffer's registered read.
  - weight_valid is cleared by reset.
- Occupancy update:
  - occupancy_next = occupancy + credit(write) - (buf_out_en ? 1 : 0).
  - Simultaneous write and read nets +1 (or 0 for an odd tail).
  - Occupancy never exceeds BUF_ELEMS and never underflows; both are assertion targets.
  - The read decision uses the current occupancy, so a word written this cycle is not readable until the next cycle.
- busy = (state==LOAD || state==DRAIN).
- Arithmetic:
  - All counters are unsigned CNT_W.
  - words_left is computed as (num_weights+1)>>1 at CNT_W+1 bits, so no overflow at the maximum count.
  - num_weights up to 2^CNT_W-1 is supported.
- pe_ready low stalls reads only; writes continue until the buffer is full.

Decomposition:
- Shared package weight_pkg holds:
  - typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} wctrl_state_t
  - localparam WORD_W = 32
  - localparam ELEMS_PER_WORD = 2
- Single sub-module: wb_occupancy_cnt, the up-by-credit/down-by-1 counter with full/empty compare.
  - full = occupancy > BUF_ELEMS-2; empty = occupancy == 0.
- The FSM and handshake logic stay in the top module.

Test Plan:
- Basic job: num_weights=9, s_valid always 1, pe_ready always 1.
  - Expected: 5 words accepted, 9 buf_out_en pulses, weight_valid 9 cycles.
  - Odd tail: the last word's credit is 1.
  - done pulses once, exactly one cycle after the 9th pop reaches sent=9 in DRAIN; busy then drops.
- Back-pressure fill: num_weights=20, pe_ready=0.
  - Expected: s_ready drops after 7 words (occupancy 14).
  - Set pe_ready=1: one element pops per cycle; s_ready reasserts at occupancy 12; total 20 pops, then done.
- Simultaneous events: occupancy=13 with a write and a read in the same cycle.
  - Expected: s_ready=0 that cycle (13 > 12), so the write is blocked; occupancy=12 next cycle.
  - Next cycle write+read -> occupancy 13.
- Zero job: start with num_weights=0.
  - Expected: done one cycle after start, no s_ready, no buf_out_en.
- Ignored start and reset mid-job:
  - start pulsed in LOAD -> no effect on the counters.
  - rst=1 mid-DRAIN -> next cycle all outputs 0, state IDLE, no done.
  - A new start then runs a fresh 4-element job correctly.
